// File: rtl/iir_decim_pkg.sv
// ----------------------------------------------------------------------------
// iir_decim_pkg
// Shared constants, types and helper functions for the IIR decimator slice.
//   clog2_const : constant-foldable ceil(log2(value)), valid in port widths.
//   sat_round   : round-half-up arithmetic right shift followed by clipping to
//                 a signed out_width range; reports whether clipping happened.
//   ACC_WIDTH / LVL_WIDTH : widths for the default block configuration.
// ----------------------------------------------------------------------------
package iir_decim_pkg;

    // Working width for the rounding/saturation helper. Every accumulator
    // must be narrower than this so the rounding offset can never overflow.
    localparam int CALC_WIDTH = 64;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DECIM      = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int clog2_const(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    localparam int ACC_WIDTH = DEF_WIDTH + clog2_const(DEF_DECIM);
    localparam int LVL_WIDTH = clog2_const(DEF_FIFO_DEPTH + 1);

    typedef struct packed {
        logic signed [CALC_WIDTH-1:0] clipped;
        logic                         sat;
    } sat_round_t;

    // (value + 2^(shift-1)) >>> shift, then clip to out_width signed bits.
    // shift must be at least 1.
    function automatic sat_round_t sat_round(
        input logic signed [CALC_WIDTH-1:0] value,
        input int                           shift,
        input int                           out_width
    );
        logic signed [CALC_WIDTH-1:0] w_half;
        logic signed [CALC_WIDTH-1:0] w_rnd;
        logic signed [CALC_WIDTH-1:0] w_max;
        logic signed [CALC_WIDTH-1:0] w_min;
        sat_round_t                   res;
        w_half = 64'sd1 <<< (shift - 1);
        w_rnd  = (value + w_half) >>> shift;
        w_max  = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        w_min  = -(64'sd1 <<< (out_width - 1));
        if (w_rnd > w_max) begin
            res.clipped = w_max;
            res.sat     = 1'b1;
        end else if (w_rnd < w_min) begin
            res.clipped = w_min;
            res.sat     = 1'b1;
        end else begin
            res.clipped = w_rnd;
            res.sat     = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// ----------------------------------------------------------------------------
// sample_fifo
// Small first-in first-out buffer with a registered head word.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full unless popping this edge)
//   pop        : remove the head (ignored when empty)
//   head       : oldest entry, 0 when empty; changes only on a pop or on a
//                write into an empty buffer
//   empty/full : occupancy status (registered)
//   level      : current number of entries
// ----------------------------------------------------------------------------
module sample_fifo
    import iir_decim_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_data,
    input  logic                            pop,
    output logic [WIDTH-1:0]                head,
    output logic                            empty,
    output logic                            full,
    output logic [clog2_const(DEPTH+1)-1:0] level
);

    localparam int PTR_W = clog2_const(DEPTH);
    localparam int LVL_W = clog2_const(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_head;
    logic             r_empty;
    logic             r_full;

    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_rd_next;
    logic [LVL_W-1:0] w_remaining;
    logic [LVL_W-1:0] w_level_next;
    logic [WIDTH-1:0] w_head_next;

    // Qualify push/pop and compute next-state occupancy and read pointer.
    // A push at full is accepted only when a pop frees a slot on the same edge.
    always_comb begin
        w_do_pop     = pop && !r_empty;
        w_do_push    = push && (!r_full || w_do_pop);
        w_rd_next    = w_do_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
        w_remaining  = w_do_pop ? (r_level - LVL_W'(1)) : r_level;
        w_level_next = w_do_push ? (w_remaining + LVL_W'(1)) : w_remaining;
    end

    // Next head word: if nothing older survives the pop, the incoming word
    // becomes the head directly; otherwise it is the stored entry at the new
    // read pointer.
    always_comb begin
        w_head_next = '0;
        if (w_level_next == LVL_W'(0)) begin
            w_head_next = '0;
        end else if (w_do_push && (w_remaining == LVL_W'(0))) begin
            w_head_next = push_data;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage, pointers, level and registered status/head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            r_head   <= w_head_next;
            r_empty  <= (w_level_next == LVL_W'(0));
            r_full   <= (w_level_next == LVL_FULL);
        end
    end

    assign head  = r_head;
    assign empty = r_empty;
    assign full  = r_full;
    assign level = r_level;

endmodule

// File: rtl/iir_decimator.sv
// ----------------------------------------------------------------------------
// iir_decimator
// Averages each block of DECIM signed input samples, requantises by SHIFT with
// round-half-up, saturates to OUT_WIDTH bits and buffers results in a FIFO
// read through a valid/ready handshake. Never backpressures the source:
// results arriving at a full FIFO are dropped.
//   clk, rst              : clock, asynchronous active-low reset
//   xin, xin_valid        : input sample and its qualifier
//   yout, yout_valid      : FIFO head (0 when empty) and not-empty
//   yout_ready            : sink takes the head when valid && ready
//   fifo_level            : FIFO occupancy
//   sat_flag, drop_flag   : sticky saturation / discard indicators
// ----------------------------------------------------------------------------
module iir_decimator
    import iir_decim_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DECIM      = DEF_DECIM,
    parameter int SHIFT      = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [WIDTH-1:0]             xin,
    input  logic                                xin_valid,
    output logic signed [OUT_WIDTH-1:0]         yout,
    output logic                                yout_valid,
    input  logic                                yout_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic                                sat_flag,
    output logic                                drop_flag
);

    localparam int L     = clog2_const(DECIM);
    localparam int ACC_W = WIDTH + L;
    localparam int LVL_W = clog2_const(FIFO_DEPTH + 1);
    localparam logic [L-1:0] CNT_LAST = L'(DECIM - 1);

    logic signed [ACC_W-1:0]     r_acc;
    logic [L-1:0]                r_cnt;
    logic [OUT_WIDTH-1:0]        r_res;
    logic                        r_pend;
    logic                        r_sat;
    logic                        r_drop;

    logic signed [ACC_W-1:0]     w_sum;
    logic signed [CALC_WIDTH-1:0] w_sum_ext;
    sat_round_t                  w_sr;
    logic                        w_block_done;
    logic                        w_pop;
    logic [OUT_WIDTH-1:0]        w_head;
    logic                        w_empty;
    logic                        w_full;
    logic [LVL_W-1:0]            w_level;

    // Block sum including the current sample, then round/shift/saturate.
    // The accumulator is L bits wider than a sample so DECIM samples never wrap.
    always_comb begin
        w_sum        = r_acc + {{L{xin[WIDTH-1]}}, xin};
        w_sum_ext    = {{(CALC_WIDTH - ACC_W){w_sum[ACC_W-1]}}, w_sum};
        w_sr         = sat_round(w_sum_ext, L + SHIFT, OUT_WIDTH);
        w_block_done = xin_valid && (r_cnt == CNT_LAST);
        w_pop        = !w_empty && yout_ready;
    end

    // Accumulator and in-block sample counter; idle cycles hold both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (xin_valid) begin
            if (r_cnt == CNT_LAST) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + L'(1);
            end
        end
    end

    // Result register with its pending bit (pending lasts one cycle: the
    // write stage consumes it on the following edge) and sticky saturation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res  <= '0;
            r_pend <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_pend <= w_block_done;
            if (w_block_done) begin
                r_res <= w_sr.clipped[OUT_WIDTH-1:0];
                if (w_sr.sat) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    // Sticky drop: pending result meets a full FIFO that is not popping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= 1'b0;
        end else if (r_pend && w_full && !w_pop) begin
            r_drop <= 1'b1;
        end
    end

    sample_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_pend),
        .push_data (r_res),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .level     (w_level)
    );

    assign yout       = w_head;
    assign yout_valid = !w_empty;
    assign fifo_level = w_level;
    assign sat_flag   = r_sat;
    assign drop_flag  = r_drop;

endmodule

// File: tb/tb_iir_decimator.sv
// ----------------------------------------------------------------------------
// tb_iir_decimator
// Main instance: DECIM=4, SHIFT=0, OUT_WIDTH=16, FIFO_DEPTH=4, compared every
// cycle against a queue-based reference model. A second instance with
// SHIFT=16 shares the inputs and is checked in the requantisation scenario.
// ----------------------------------------------------------------------------
module tb_iir_decimator;

    localparam int DECIM = 4;
    localparam int DEPTH = 4;
    localparam int LOG_D = 2;

    logic               clk;
    logic               rst;
    logic signed [31:0] xin;
    logic               xin_valid;
    logic               yout_ready;
    logic signed [15:0] yout;
    logic               yout_valid;
    logic [2:0]         fifo_level;
    logic               sat_flag;
    logic               drop_flag;
    logic signed [15:0] yout_b;
    logic               yout_valid_b;
    logic [2:0]         fifo_level_b;
    logic               sat_flag_b;
    logic               drop_flag_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    longint m_blk[$];
    longint m_fifo[$];
    bit     m_pend;
    longint m_pend_val;
    bit     m_sat;
    bit     m_drop;

    iir_decimator #(
        .WIDTH(32), .DECIM(DECIM), .SHIFT(0), .OUT_WIDTH(16), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst), .xin(xin), .xin_valid(xin_valid),
        .yout(yout), .yout_valid(yout_valid), .yout_ready(yout_ready),
        .fifo_level(fifo_level), .sat_flag(sat_flag), .drop_flag(drop_flag)
    );

    iir_decimator #(
        .WIDTH(32), .DECIM(DECIM), .SHIFT(16), .OUT_WIDTH(16), .FIFO_DEPTH(DEPTH)
    ) u_dut_sh16 (
        .clk(clk), .rst(rst), .xin(xin), .xin_valid(xin_valid),
        .yout(yout_b), .yout_valid(yout_valid_b), .yout_ready(yout_ready),
        .fifo_level(fifo_level_b), .sat_flag(sat_flag_b), .drop_flag(drop_flag_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Block average: floor((sum + half) / 2^n), then clip to 16-bit signed.
    function automatic longint avg_round(input longint sum, input int sh, output bit sat);
        longint div;
        longint q;
        longint r;
        div = longint'(1) << (LOG_D + sh);
        q   = sum + div / 2;
        r   = q / div;
        if ((q % div != 0) && (q < 0)) r = r - 1;
        sat = 1'b0;
        if (r > 32767)  begin r = 32767;  sat = 1'b1; end
        if (r < -32768) begin r = -32768; sat = 1'b1; end
        return r;
    endfunction

    task automatic model_clear();
        m_blk.delete();
        m_fifo.delete();
        m_pend = 1'b0;
        m_pend_val = 0;
        m_sat = 1'b0;
        m_drop = 1'b0;
    endtask

    // One rising edge of the reference behaviour, using pre-edge state.
    task automatic model_edge(input bit v, input longint x, input bit rdy);
        bit     pop;
        bit     s;
        longint sum;
        pop = (m_fifo.size() > 0) && rdy;
        if (pop) void'(m_fifo.pop_front());
        if (m_pend) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend_val);
            else m_drop = 1'b1;
        end
        m_pend = 1'b0;
        if (v) begin
            m_blk.push_back(x);
            if (m_blk.size() == DECIM) begin
                sum = 0;
                foreach (m_blk[i]) sum += m_blk[i];
                m_pend_val = avg_round(sum, 0, s);
                m_pend = 1'b1;
                if (s) m_sat = 1'b1;
                m_blk.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("yout",  longint'(yout), (m_fifo.size() > 0) ? m_fifo[0] : 0);
        chk("valid", longint'(yout_valid), longint'(m_fifo.size() > 0));
        chk("level", longint'(fifo_level), longint'(m_fifo.size()));
        chk("sat",   longint'(sat_flag), longint'(m_sat));
        chk("drop",  longint'(drop_flag), longint'(m_drop));
    endtask

    task automatic cyc(input longint x, input bit v, input bit rdy);
        xin        = 32'(x);
        xin_valid  = v;
        yout_ready = rdy;
        @(posedge clk);
        model_edge(v, x, rdy);
        #1;
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 1'b0, rdy);
    endtask

    // Hold reset for n edges with random activity; all outputs must be 0.
    task automatic do_reset(input int n);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < n; i++) begin
            xin        = $urandom;
            xin_valid  = 1'b1;
            yout_ready = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            chk("rst_yout",  longint'(yout), 0);
            chk("rst_valid", longint'(yout_valid), 0);
            chk("rst_level", longint'(fifo_level), 0);
            chk("rst_sat",   longint'(sat_flag), 0);
            chk("rst_drop",  longint'(drop_flag), 0);
        end
        rst = 1'b1;
        xin_valid = 1'b0;
    endtask

    initial begin
        bit gap_pat [7];
        rst = 1'b0;
        xin = '0;
        xin_valid = 1'b0;
        yout_ready = 1'b0;
        gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset, then quiet cycles keep the output invalid
        #2;
        do_reset(3);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("post_rst_valid", longint'(yout_valid), 0);

        // Rounding, positive and negative
        for (int i = 1; i <= 4; i++) cyc(i, 1'b1, 1'b1);
        idle(1'b1);
        chk("round_pos", longint'(yout), 3);
        chk("round_pos_valid", longint'(yout_valid), 1);
        for (int i = 1; i <= 4; i++) cyc(-i, 1'b1, 1'b1);
        idle(1'b1);
        chk("round_neg", longint'(yout), -2);

        // Requantisation with SHIFT=16 on the second instance
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(64'h18000, 1'b1, 1'b1);
        idle(1'b1);
        chk("round_shift16", longint'(yout_b), 2);
        chk("shift16_sat", longint'(sat_flag_b), 0);

        // Saturation
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(40000, 1'b1, 1'b1);
        idle(1'b1);
        chk("sat_pos", longint'(yout), 32767);
        chk("sat_flag", longint'(sat_flag), 1);
        for (int i = 0; i < 4; i++) cyc(-40000, 1'b1, 1'b1);
        idle(1'b1);
        chk("sat_neg", longint'(yout), -32768);

        // Gapped input: one result only
        do_reset(1);
        foreach (gap_pat[i]) cyc(gap_pat[i] ? 8 : 999, gap_pat[i], 1'b0);
        idle(1'b0);
        chk("gap_yout", longint'(yout), 8);
        chk("gap_level", longint'(fifo_level), 1);

        // Backpressure: five blocks into a four-entry FIFO
        do_reset(1);
        for (int i = 0; i < 20; i++) cyc((i / 4 + 1) * 10, 1'b1, 1'b0);
        idle(1'b0);
        chk("bp_level", longint'(fifo_level), 4);
        chk("bp_drop", longint'(drop_flag), 1);
        chk("bp_head", longint'(yout), 10);
        for (int j = 1; j <= 3; j++) begin
            idle(1'b1);
            chk("bp_drain", longint'(yout), (j + 1) * 10);
        end
        idle(1'b1);
        chk("bp_empty", longint'(fifo_level), 0);

        // Full FIFO with a pop on the write edge: no drop
        do_reset(1);
        for (int i = 0; i < 20; i++) cyc($urandom_range(200) - 100, 1'b1, 1'b0);
        chk("full_pre_level", longint'(fifo_level), 4);
        idle(1'b1);
        chk("full_pop_level", longint'(fifo_level), 4);
        chk("full_pop_drop", longint'(drop_flag), 0);

        // Reset mid-block discards the partial sum
        do_reset(1);
        cyc(100, 1'b1, 1'b1);
        cyc(100, 1'b1, 1'b1);
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(8, 1'b1, 1'b1);
        idle(1'b1);
        chk("midrst_yout", longint'(yout), 8);

        // Randomised traffic
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            cyc(longint'($urandom_range(100000)) - 50000,
                ($urandom_range(9) < 7), ($urandom_range(9) < 4));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
